// File: rtl/bht_update_controller.sv
// Update sequencer for the 2-bit branch history table: buffers resolved
// branches, drains one per cycle, runs clear sweeps, counts mispredicts.
module bht_update_controller #(
  parameter int LOWER = 5,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     arst_n,
  input  logic                     upd_valid,
  input  logic [LOWER-1:0]         upd_addr,
  input  logic                     upd_taken,
  input  logic                     upd_predicted,
  output logic                     upd_ready,
  input  logic                     clr_req,
  output logic                     clr_busy,
  output logic                     bht_en,
  output logic [LOWER-1:0]         bht_write_addr,
  output logic                     bht_was_taken,
  output logic                     bht_clear,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [15:0]              mispredict_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [LOWER-1:0] LAST_IDX = '1;

  typedef enum logic {RUN, CLEAR} state_t;

  typedef struct packed {
    logic [LOWER-1:0] addr;
    logic             taken;
  } upd_t;

  state_t           state;
  upd_t             mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [LOWER-1:0] sweep_idx;
  logic             push;
  logic             pop;
  logic             miss;
  upd_t             head;

  assign upd_ready = (state == RUN) && (fifo_count < DEPTH_C);
  assign push      = upd_valid && upd_ready;
  assign pop       = (fifo_count != '0);
  assign miss      = push && (upd_taken != upd_predicted);
  assign head      = mem[rd_ptr];

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push && !clr_req) begin
      mem[wr_ptr] <= '{addr: upd_addr, taken: upd_taken};
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state          <= RUN;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fifo_count     <= '0;
      sweep_idx      <= '0;
      clr_busy       <= 1'b0;
      bht_en         <= 1'b0;
      bht_write_addr <= '0;
      bht_was_taken  <= 1'b0;
      bht_clear      <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (clr_req) begin
            // flush drops queued work and any same-edge push
            state      <= CLEAR;
            clr_busy   <= 1'b1;
            sweep_idx  <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            bht_en     <= 1'b0;
            bht_clear  <= 1'b0;
          end else begin
            bht_en    <= pop;
            bht_clear <= 1'b0;
            if (pop) begin
              bht_write_addr <= head.addr;
              bht_was_taken  <= head.taken;
              rd_ptr         <= rd_ptr + 1'b1;
            end
            if (push) begin
              wr_ptr <= wr_ptr + 1'b1;
            end
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
          end
        end
        CLEAR: begin
          bht_en         <= 1'b1;
          bht_clear      <= 1'b1;
          bht_write_addr <= sweep_idx;
          bht_was_taken  <= 1'b0;
          sweep_idx      <= sweep_idx + 1'b1;
          if (sweep_idx == LAST_IDX) begin
            state    <= RUN;
            clr_busy <= 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      mispredict_cnt <= '0;
    end else if (miss && (mispredict_cnt != 16'hFFFF)) begin
      mispredict_cnt <= mispredict_cnt + 16'd1;
    end
  end

endmodule
